// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit for a simple bus-based datapath. Runs a
//   three-cycle fetch (T0..T2) followed by a class-dependent execute phase
//   (T3..T6), then either loops back to fetch or parks in IDLE depending on
//   Run. Illegal opcodes stop the machine in HALT until Clear.
//
// Ports
//   Clock            system clock, rising edge active
//   Clear            asynchronous active-low reset
//   Run              start / continue enable
//   IR[31:0]         instruction register from the datapath
//   PCout..Read      single-bit datapath controls
//   Rout[15:0]       one-hot register bus-drive select
//   Rin[15:0]        one-hot register load select
//   ALUop[12:0]      one-hot ALU operation {NOT,NEG,DIV,MUL,OR,AND,ROL,ROR,
//                    SHL,SHRA,SHR,SUB,ADD}
//   Done             final execute cycle of an instruction
//   Halted           machine is in HALT
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [12:0] ALUop,
  output logic        Done,
  output logic        Halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
  } state_t;

  // Bit positions inside the packed single-bit control vector
  localparam logic [15:0] K_PCOUT    = 16'h8000;
  localparam logic [15:0] K_MDROUT   = 16'h4000;
  localparam logic [15:0] K_ZHIGHOUT = 16'h2000;
  localparam logic [15:0] K_ZLOWOUT  = 16'h1000;
  localparam logic [15:0] K_PCIN     = 16'h0200;
  localparam logic [15:0] K_MARIN    = 16'h0100;
  localparam logic [15:0] K_MDRIN    = 16'h0080;
  localparam logic [15:0] K_IRIN     = 16'h0040;
  localparam logic [15:0] K_ZIN      = 16'h0020;
  localparam logic [15:0] K_YIN      = 16'h0010;
  localparam logic [15:0] K_HIIN     = 16'h0008;
  localparam logic [15:0] K_LOIN     = 16'h0004;
  localparam logic [15:0] K_INCPC    = 16'h0002;
  localparam logic [15:0] K_READ     = 16'h0001;

  state_t      state_r, state_next_s;
  logic [4:0]  op_r, op_d_s;
  logic [3:0]  ra_r, rb_r, rc_r, ra_d_s, rb_d_s, rc_d_s;
  logic [15:0] ctl_r, ctl_next_s;
  logic [15:0] rout_r, rout_next_s, rin_r, rin_next_s;
  logic [12:0] alu_r, alu_next_s;
  logic        done_r, done_next_s, halted_r, halted_next_s;
  logic        ir_unused_s;

  function automatic logic is_alu3(input logic [4:0] op);
    return (op <= 5'd8);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'd15) || (op == 5'd16);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == 5'd17) || (op == 5'd18);
  endfunction

  function automatic logic [15:0] reg_sel(input logic [3:0] n);
    return 16'h0001 << n;
  endfunction

  function automatic logic [12:0] alu_sel(input logic [4:0] op);
    logic [12:0] sel;
    case (op)
      5'd0:    sel = 13'h0001;
      5'd1:    sel = 13'h0002;
      5'd2:    sel = 13'h0004;
      5'd3:    sel = 13'h0008;
      5'd4:    sel = 13'h0010;
      5'd5:    sel = 13'h0020;
      5'd6:    sel = 13'h0040;
      5'd7:    sel = 13'h0080;
      5'd8:    sel = 13'h0100;
      5'd15:   sel = 13'h0200;
      5'd16:   sel = 13'h0400;
      5'd17:   sel = 13'h0800;
      5'd18:   sel = 13'h1000;
      default: sel = 13'h0000;
    endcase
    return sel;
  endfunction

  // The low IR bits carry no control information.
  assign ir_unused_s = ^IR[14:0];

  // Fields that the decode for the next cycle must see: the live IR on the
  // T2->T3 edge (the same edge that latches it), the latched copy otherwise.
  assign op_d_s = (state_r == S_T2) ? IR[31:27] : op_r;
  assign ra_d_s = (state_r == S_T2) ? IR[26:23] : ra_r;
  assign rb_d_s = (state_r == S_T2) ? IR[22:19] : rb_r;
  assign rc_d_s = (state_r == S_T2) ? IR[18:15] : rc_r;

  // Next-state logic; Done states return to T0 or IDLE based on Run.
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE: state_next_s = Run ? S_T0 : S_IDLE;
      S_T0:   state_next_s = S_T1;
      S_T1:   state_next_s = S_T2;
      S_T2:   state_next_s = S_T3;
      S_T3: begin
        if (is_alu3(op_r) || is_muldiv(op_r) || is_unary(op_r)) begin
          state_next_s = S_T4;
        end else begin
          state_next_s = S_HALT;
        end
      end
      S_T4: begin
        if (is_unary(op_r)) begin
          state_next_s = Run ? S_T0 : S_IDLE;
        end else begin
          state_next_s = S_T5;
        end
      end
      S_T5: begin
        if (is_muldiv(op_r)) begin
          state_next_s = S_T6;
        end else begin
          state_next_s = Run ? S_T0 : S_IDLE;
        end
      end
      S_T6:   state_next_s = Run ? S_T0 : S_IDLE;
      S_HALT: state_next_s = S_HALT;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, so the registers below hold
  // the Moore outputs of the current state.
  always_comb begin
    ctl_next_s    = 16'h0000;
    rout_next_s   = 16'h0000;
    rin_next_s    = 16'h0000;
    alu_next_s    = 13'h0000;
    done_next_s   = 1'b0;
    halted_next_s = 1'b0;
    case (state_next_s)
      S_T0: ctl_next_s = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
      S_T1: ctl_next_s = K_ZLOWOUT | K_PCIN | K_READ | K_MDRIN;
      S_T2: ctl_next_s = K_MDROUT | K_IRIN;
      S_T3: begin
        if (is_alu3(op_d_s)) begin
          ctl_next_s  = K_YIN;
          rout_next_s = reg_sel(rb_d_s);
        end else if (is_muldiv(op_d_s)) begin
          ctl_next_s  = K_YIN;
          rout_next_s = reg_sel(ra_d_s);
        end else if (is_unary(op_d_s)) begin
          ctl_next_s  = K_ZIN;
          rout_next_s = reg_sel(rb_d_s);
          alu_next_s  = alu_sel(op_d_s);
        end else begin
          ctl_next_s  = 16'h0000;
        end
      end
      S_T4: begin
        if (is_alu3(op_d_s)) begin
          ctl_next_s  = K_ZIN;
          rout_next_s = reg_sel(rc_d_s);
          alu_next_s  = alu_sel(op_d_s);
        end else if (is_muldiv(op_d_s)) begin
          ctl_next_s  = K_ZIN;
          rout_next_s = reg_sel(rb_d_s);
          alu_next_s  = alu_sel(op_d_s);
        end else begin
          ctl_next_s  = K_ZLOWOUT;
          rin_next_s  = reg_sel(ra_d_s);
          done_next_s = 1'b1;
        end
      end
      S_T5: begin
        if (is_muldiv(op_d_s)) begin
          ctl_next_s  = K_ZLOWOUT | K_LOIN;
        end else begin
          ctl_next_s  = K_ZLOWOUT;
          rin_next_s  = reg_sel(ra_d_s);
          done_next_s = 1'b1;
        end
      end
      S_T6: begin
        ctl_next_s  = K_ZHIGHOUT | K_HIIN;
        done_next_s = 1'b1;
      end
      S_HALT: halted_next_s = 1'b1;
      default: ctl_next_s = 16'h0000;
    endcase
  end

  // State, latched instruction fields and registered outputs.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_r  <= S_IDLE;
      op_r     <= 5'd0;
      ra_r     <= 4'd0;
      rb_r     <= 4'd0;
      rc_r     <= 4'd0;
      ctl_r    <= 16'h0000;
      rout_r   <= 16'h0000;
      rin_r    <= 16'h0000;
      alu_r    <= 13'h0000;
      done_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_d_s;
      ra_r     <= ra_d_s;
      rb_r     <= rb_d_s;
      rc_r     <= rc_d_s;
      ctl_r    <= ctl_next_s;
      rout_r   <= rout_next_s;
      rin_r    <= rin_next_s;
      alu_r    <= alu_next_s;
      done_r   <= done_next_s;
      halted_r <= halted_next_s;
    end
  end

  assign {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, PCin, MARin,
          MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read} = ctl_r;
  assign Rout   = rout_r;
  assign Rin    = rin_r;
  assign ALUop  = alu_r;
  assign Done   = done_r;
  assign Halted = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed instruction sequences with literal expectations, followed by a
//   randomized instruction/Run/Clear stream compared every cycle against a
//   queue-based model of the expected control pattern.
module tb_control_sequencer;

  logic        Clock, Clear, Run;
  logic [31:0] IR;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, PCin, MARin;
  logic MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read;
  logic [15:0] Rout, Rin;
  logic [12:0] ALUop;
  logic        Done, Halted;

  int n_checks = 0;
  int n_pass   = 0;
  bit sim_on   = 1'b0;

  localparam logic [15:0] C_PCOUT    = 16'h8000;
  localparam logic [15:0] C_MDROUT   = 16'h4000;
  localparam logic [15:0] C_ZHIGHOUT = 16'h2000;
  localparam logic [15:0] C_ZLOWOUT  = 16'h1000;
  localparam logic [15:0] C_PCIN     = 16'h0200;
  localparam logic [15:0] C_MARIN    = 16'h0100;
  localparam logic [15:0] C_MDRIN    = 16'h0080;
  localparam logic [15:0] C_IRIN     = 16'h0040;
  localparam logic [15:0] C_ZIN      = 16'h0020;
  localparam logic [15:0] C_YIN      = 16'h0010;
  localparam logic [15:0] C_HIIN     = 16'h0008;
  localparam logic [15:0] C_LOIN     = 16'h0004;
  localparam logic [15:0] C_INCPC    = 16'h0002;
  localparam logic [15:0] C_READ     = 16'h0001;

  localparam logic [62:0] F0 = {C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 47'd0};
  localparam logic [62:0] F1 = {C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 47'd0};
  localparam logic [62:0] F2 = {C_MDROUT | C_IRIN, 47'd0};
  localparam logic [62:0] HALT_V = 63'd1;
  localparam logic [62:0] ZERO_V = 63'd0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .Zin(Zin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .ALUop(ALUop), .Done(Done), .Halted(Halted)
  );

  logic [62:0] dut_vec;
  assign dut_vec = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, PCin, MARin,
                    MDRin, IRin, Zin, Yin, HIin, LOin, IncPC, Read,
                    Rout, Rin, ALUop, Done, Halted};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [62:0] v(input logic [15:0] ctl, input logic [15:0] rout,
                                    input logic [15:0] rin, input logic [12:0] alu,
                                    input logic done, input logic halted);
    return {ctl, rout, rin, alu, done, halted};
  endfunction

  task automatic check(input string name, input logic [62:0] got, input logic [62:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [62:0] q[$];
  logic [62:0] exp_vec = 63'd0;
  bit need_decode = 1'b0, halt_pending = 1'b0, halted_m = 1'b0;

  function automatic logic [15:0] oh16(input int n);
    return 16'h0001 << n;
  endfunction

  function automatic logic [12:0] alu_of(input int op);
    return 13'h0001 << ((op <= 8) ? op : op - 6);
  endfunction

  task automatic model_decode(input logic [31:0] ir);
    int op, ra, rb, rc;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    if (op <= 8) begin
      q.push_back(v(C_YIN, oh16(rb), 16'd0, 13'd0, 1'b0, 1'b0));
      q.push_back(v(C_ZIN, oh16(rc), 16'd0, alu_of(op), 1'b0, 1'b0));
      q.push_back(v(C_ZLOWOUT, 16'd0, oh16(ra), 13'd0, 1'b1, 1'b0));
    end else if (op == 15 || op == 16) begin
      q.push_back(v(C_YIN, oh16(ra), 16'd0, 13'd0, 1'b0, 1'b0));
      q.push_back(v(C_ZIN, oh16(rb), 16'd0, alu_of(op), 1'b0, 1'b0));
      q.push_back(v(C_ZLOWOUT | C_LOIN, 16'd0, 16'd0, 13'd0, 1'b0, 1'b0));
      q.push_back(v(C_ZHIGHOUT | C_HIIN, 16'd0, 16'd0, 13'd0, 1'b1, 1'b0));
    end else if (op == 17 || op == 18) begin
      q.push_back(v(C_ZIN, oh16(rb), 16'd0, alu_of(op), 1'b0, 1'b0));
      q.push_back(v(C_ZLOWOUT, 16'd0, oh16(ra), 13'd0, 1'b1, 1'b0));
    end else begin
      q.push_back(ZERO_V);
      halt_pending = 1'b1;
    end
  endtask

  always @(posedge Clock) begin
    if (Clear) begin
      if (halted_m) exp_vec = HALT_V;
      else if (q.size() != 0) exp_vec = q.pop_front();
      else if (halt_pending) begin
        halt_pending = 1'b0; halted_m = 1'b1; exp_vec = HALT_V;
      end else if (need_decode) begin
        need_decode = 1'b0; model_decode(IR); exp_vec = q.pop_front();
      end else if (Run) begin
        q.push_back(F1); q.push_back(F2); need_decode = 1'b1; exp_vec = F0;
      end else exp_vec = ZERO_V;
    end
  end

  always @(negedge Clear) begin
    q.delete();
    need_decode = 1'b0; halt_pending = 1'b0; halted_m = 1'b0;
    exp_vec = ZERO_V;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    if (sim_on) begin
      check("cycle", dut_vec, exp_vec);
      n_checks++;
      if ($countones({PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Rout}) <= 1 &&
          $countones(Rin) <= 1 && $countones(ALUop) <= 1)
        n_pass++;
      else
        $display("FAIL exclusivity: Rout=%h Rin=%h ALUop=%h drv=%b", Rout, Rin, ALUop,
                 {PCout, MDRout, Zhighout, Zlowout, HIout, LOout});
    end
  end

  task automatic step(input string name, input logic [62:0] want);
    @(negedge Clock);
    check(name, dut_vec, want);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    int k;
    k = $urandom_range(0, 39);
    if (k == 0) op = 5'($urandom_range(19, 31));
    else if (k == 1) op = 5'($urandom_range(9, 14));
    else begin
      k = $urandom_range(0, 12);
      op = (k <= 8) ? 5'(k) : 5'(k + 6);
    end
    return {op, 27'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    Clear = 1'b1; Run = 1'b0; IR = 32'd0;
    #1 Clear = 1'b0;
    #1 check("reset", dut_vec, ZERO_V);
    @(negedge Clock);
    Clear = 1'b1; sim_on = 1'b1;

    // SHRA R1,R2,R3 with Run held high
    Run = 1'b1; IR = 32'h18918000;
    step("shra_t0", F0); step("shra_t1", F1); step("shra_t2", F2);
    step("shra_t3", v(C_YIN, 16'h0004, 16'h0000, 13'h0000, 1'b0, 1'b0));
    step("shra_t4", v(C_ZIN, 16'h0008, 16'h0000, 13'h0008, 1'b0, 1'b0));
    step("shra_t5", v(C_ZLOWOUT, 16'h0000, 16'h0002, 13'h0000, 1'b1, 1'b0));

    // MUL R4,R5 follows immediately
    IR = 32'h7A280000;
    step("mul_t0", F0); step("mul_t1", F1); step("mul_t2", F2);
    step("mul_t3", v(C_YIN, 16'h0010, 16'h0000, 13'h0000, 1'b0, 1'b0));
    step("mul_t4", v(C_ZIN, 16'h0020, 16'h0000, 13'h0200, 1'b0, 1'b0));
    step("mul_t5", v(C_ZLOWOUT | C_LOIN, 16'h0000, 16'h0000, 13'h0000, 1'b0, 1'b0));
    step("mul_t6", v(C_ZHIGHOUT | C_HIIN, 16'h0000, 16'h0000, 13'h0000, 1'b1, 1'b0));

    // NOT R6,R7; Run drops mid-instruction, IR changes after latching
    IR = 32'h93380000;
    step("not_t0", F0);
    Run = 1'b0;
    step("not_t1", F1); step("not_t2", F2);
    step("not_t3", v(C_ZIN, 16'h0080, 16'h0000, 13'h1000, 1'b0, 1'b0));
    IR = 32'h00918000;
    step("not_t4", v(C_ZLOWOUT, 16'h0000, 16'h0040, 13'h0000, 1'b1, 1'b0));
    step("not_idle0", ZERO_V); step("not_idle1", ZERO_V);

    // Illegal opcode halts; Run toggling ignored
    Run = 1'b1; IR = 32'hF8000000;
    step("ill_t0", F0); step("ill_t1", F1); step("ill_t2", F2);
    step("ill_t3", ZERO_V);
    step("halt0", HALT_V);
    for (int i = 0; i < 4; i++) begin
      Run = ~Run; IR = $urandom;
      step("halt_hold", HALT_V);
    end
    #2 Clear = 1'b0;
    #1 check("halt_clear", dut_vec, ZERO_V);
    @(negedge Clock);
    Clear = 1'b1;

    // ADD R1,R2,R3 interrupted by Clear during T4
    Run = 1'b1; IR = 32'h00918000;
    step("add_t0", F0); step("add_t1", F1); step("add_t2", F2);
    step("add_t3", v(C_YIN, 16'h0004, 16'h0000, 13'h0000, 1'b0, 1'b0));
    step("add_t4", v(C_ZIN, 16'h0008, 16'h0000, 13'h0001, 1'b0, 1'b0));
    #2 Clear = 1'b0;
    #1 check("add_clear_async", dut_vec, ZERO_V);
    @(negedge Clock);
    Clear = 1'b1; Run = 1'b0;
    step("post_clear_idle0", ZERO_V); step("post_clear_idle1", ZERO_V);
    step("post_clear_idle2", ZERO_V);
    Run = 1'b1;
    step("restart_t0", F0);

    // Randomized stream
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      Run = ($urandom_range(0, 3) != 0);
      IR = rand_instr();
      if ($urandom_range(0, 59) == 0) begin
        #2 Clear = 1'b0;
        #1 check("rand_clear", dut_vec, ZERO_V);
        @(negedge Clock);
        Clear = 1'b1;
      end
    end

    @(negedge Clock);
    sim_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
